// File: rtl/wshb_pkg.sv
// Shared Wishbone cycle-type codes and the pixel fetcher state type.
package wshb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/wshb_pixel_fetcher_fifo.sv
// Synchronous show-ahead (first-word-fall-through) FIFO with occupancy count.
// The head word is visible on rd_data whenever empty is low; rd_en pops it.
module pixel_fifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // A pop frees the head slot in the same cycle, so a full FIFO may still accept a write alongside a read.
  assign do_rd = rd_en & ~empty & ~flush;
  assign do_wr = wr_en & (~full | do_rd) & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(wr_en && !flush && full && !rd_en));

endmodule

// File: rtl/wshb_pixel_fetcher.sv
// Wishbone read master walking the frame buffer linearly into a pixel FIFO for the VGA generator.
// Define BURST_CTI_EN for registered-feedback incrementing bursts; otherwise classic single cycles.
module wshb_pixel_fetcher
  import wshb_pkg::*;
#(
  parameter int          HDISP       = 800,
  parameter int          VDISP       = 480,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 256,
  parameter int          ALMOST_FULL = 224,
  parameter int          BURST_LEN   = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] wshb_adr,
  input  logic [15:0] wshb_dat_sm,
  output logic [15:0] wshb_dat_ms,
  output logic        wshb_we,
  output logic [1:0]  wshb_sel,
  output logic        wshb_stb,
  output logic        wshb_cyc,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack,
  input  logic        frame_rst,
  input  logic        pix_rd,
  output logic [15:0] pix_data,
  output logic        pix_empty,
  output logic        underflow
);

  localparam int NPIX = HDISP * VDISP;
  localparam int CW   = (NPIX > 2) ? $clog2(NPIX) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

  if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (ALMOST_FULL + BURST_LEN > FIFO_DEPTH)) begin : g_bad_cfg
    $error("wshb_pixel_fetcher: FIFO_DEPTH must be a power of 2 with room for ALMOST_FULL + BURST_LEN");
  end

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [CW-1:0] pix_cnt;
  logic [31:0]   adr_q;
  logic [AW:0]   occ;
  logic          has_room;
  logic          last_beat;
  logic          beat_done;
  logic          at_wrap;

  assign wshb_dat_ms = '0;
  assign wshb_we     = 1'b0;
  assign wshb_sel    = 2'b11;
  assign wshb_bte    = 2'b00;
  assign wshb_adr    = adr_q;

  assign at_wrap   = (pix_cnt == LAST_PIX);
  // An ack that coincides with frame_rst belongs to the abandoned frame and is dropped.
  assign beat_done = (state == REQ) & wshb_ack & ~frame_rst;

`ifdef BURST_CTI_EN
  localparam int BW = $clog2(BURST_LEN + 1);
  logic [BW-1:0] beat;

  assign has_room  = (32'(occ) + 32'(BURST_LEN)) <= 32'(ALMOST_FULL);
  // The frame wrap truncates a burst so the address never jumps back mid-burst.
  assign last_beat = (beat == BW'(BURST_LEN - 1)) | at_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat <= '0;
    end else if (frame_rst) begin
      beat <= '0;
    end else if (beat_done) begin
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end
`else
  assign has_room  = 32'(occ) < 32'(ALMOST_FULL);
  assign last_beat = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!frame_rst && has_room) state_nxt = REQ;
      REQ:  if (frame_rst || (wshb_ack && last_beat)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wshb_stb = 1'b0;
    wshb_cyc = 1'b0;
    wshb_cti = CTI_CLASSIC;
    if (state == REQ) begin
      wshb_stb = 1'b1;
      wshb_cyc = 1'b1;
`ifdef BURST_CTI_EN
      wshb_cti = last_beat ? CTI_EOB : CTI_INCR;
`endif
    end
  end

  // Address tracks the pixel counter and only moves on an accepted beat, keeping it stable through waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt   <= '0;
      adr_q     <= BASE_ADR;
      underflow <= 1'b0;
    end else if (frame_rst) begin
      pix_cnt   <= '0;
      adr_q     <= BASE_ADR;
      underflow <= 1'b0;
    end else begin
      if (beat_done) begin
        if (at_wrap) begin
          pix_cnt <= '0;
          adr_q   <= BASE_ADR;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
          adr_q   <= adr_q + 32'd2;
        end
      end
      if (pix_rd && pix_empty) underflow <= 1'b1;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (frame_rst),
    .wr_en   (beat_done),
    .wr_data (wshb_dat_sm),
    .rd_en   (pix_rd),
    .rd_data (pix_data),
    .count   (occ),
    .empty   (pix_empty)
  );

endmodule

// File: tb/tb_wshb_pixel_fetcher.sv
// Scoreboard bench for wshb_pixel_fetcher: a randomised Wishbone slave feeds a queue model of the
// pixel stream, and a monitor pops and compares whenever the consumer reads.
module tb_wshb_pixel_fetcher;

  localparam int          HDISP       = 4;
  localparam int          VDISP       = 2;
  localparam int          NPIX        = HDISP * VDISP;
  localparam int          FIFO_DEPTH  = 256;
  localparam int          ALMOST_FULL = 224;
  localparam int          BURST_LEN   = 8;
  localparam logic [31:0] BASE_ADR    = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wshb_adr;
  logic [15:0] wshb_dat_sm;
  logic [15:0] wshb_dat_ms;
  logic        wshb_we;
  logic [1:0]  wshb_sel;
  logic        wshb_stb;
  logic        wshb_cyc;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic        wshb_ack;
  logic        frame_rst;
  logic        pix_rd;
  logic [15:0] pix_data;
  logic        pix_empty;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  int          model_idx = 0;
  bit          model_uf  = 1'b0;
  int          frst_cnt  = 0;

  int max_wait     = 0;
  bit fixed_wait   = 1'b0;
  int rd_mode      = 0;
  int frst_req_cnt = 0;
  int frst_ack_arm = 0;
  int frst_req_done = 0;
  int frst_ack_done = 0;

  wshb_pixel_fetcher #(
    .HDISP       (HDISP),
    .VDISP       (VDISP),
    .BASE_ADR    (BASE_ADR),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ALMOST_FULL (ALMOST_FULL),
    .BURST_LEN   (BURST_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wshb_adr    (wshb_adr),
    .wshb_dat_sm (wshb_dat_sm),
    .wshb_dat_ms (wshb_dat_ms),
    .wshb_we     (wshb_we),
    .wshb_sel    (wshb_sel),
    .wshb_stb    (wshb_stb),
    .wshb_cyc    (wshb_cyc),
    .wshb_cti    (wshb_cti),
    .wshb_bte    (wshb_bte),
    .wshb_ack    (wshb_ack),
    .frame_rst   (frame_rst),
    .pix_rd      (pix_rd),
    .pix_data    (pix_data),
    .pix_empty   (pix_empty),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of acked words, the fetch position a plain pixel index.
  initial begin : model
    forever begin
      @(posedge clk);
      if (!rst || frame_rst) begin
        exp_q.delete();
        model_idx = 0;
        model_uf  = 1'b0;
        if (rst) frst_cnt++;
      end else begin
        if (pix_rd) begin
          if (exp_q.size() == 0) model_uf = 1'b1;
          else void'(exp_q.pop_front());
        end
        if (wshb_ack) begin
          exp_q.push_back(wshb_dat_sm);
          model_idx++;
        end
      end
    end
  end

  // Slave: random wait states, random data, and frame_rst pulses on request.
  initial begin : slave
    bit          in_req    = 1'b0;
    int          wait_left = 0;
    logic [31:0] req_adr   = '0;
    bit          ack_prev  = 1'b0;
`ifdef BURST_CTI_EN
    int          beat      = 0;
    bit          exp_last;
`endif
    wshb_ack    = 1'b0;
    wshb_dat_sm = '0;
    frame_rst   = 1'b0;
    forever begin
      @(negedge clk);
      wshb_ack  = 1'b0;
      frame_rst = 1'b0;
      if (!rst) begin
        in_req   = 1'b0;
        ack_prev = 1'b0;
      end else begin
`ifndef BURST_CTI_EN
        if (ack_prev) check_output("stb_gap_after_ack", wshb_stb, 0);
`endif
        if (wshb_stb && wshb_cyc) begin
          if (!in_req) begin
            in_req    = 1'b1;
            req_adr   = wshb_adr;
            wait_left = fixed_wait ? 5 : $urandom_range(max_wait, 0);
            check_output("req_adr", wshb_adr, BASE_ADR + 32'(2 * (model_idx % NPIX)));
            check_output("req_room", 32'(exp_q.size() < ALMOST_FULL), 1);
          end else begin
            check_output("adr_stable", wshb_adr, req_adr);
          end
`ifdef BURST_CTI_EN
          exp_last = (beat == BURST_LEN - 1) || ((model_idx % NPIX) == NPIX - 1);
          check_output("cti", 32'(wshb_cti), exp_last ? 32'd7 : 32'd2);
`else
          check_output("cti", 32'(wshb_cti), 0);
`endif
          if (wait_left == 0) begin
            wshb_ack    = 1'b1;
            wshb_dat_sm = 16'($urandom);
            in_req      = 1'b0;
`ifdef BURST_CTI_EN
            beat = exp_last ? 0 : beat + 1;
`endif
          end else begin
            wait_left--;
          end
        end else begin
          in_req = 1'b0;
`ifdef BURST_CTI_EN
          beat = 0;
`endif
        end
        if (frst_req_cnt != frst_req_done) begin
          frame_rst     = 1'b1;
          frst_req_done = frst_req_cnt;
        end else if (frst_ack_arm != frst_ack_done && wshb_ack) begin
          frame_rst     = 1'b1;
          frst_ack_done = frst_ack_arm;
        end
        ack_prev = wshb_ack;
      end
    end
  end

  // Monitor: compares the FIFO head, emptiness and underflow with the model, then chooses pix_rd.
  initial begin : monitor
    int frst_seen = 0;
    pix_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pix_rd = 1'b0;
      end else begin
        check_output("pix_empty", pix_empty, 32'(exp_q.size() == 0));
        if (exp_q.size() > 0) check_output("pix_data", pix_data, exp_q[0]);
        check_output("underflow", underflow, model_uf);
        if (frst_cnt != frst_seen) begin
          frst_seen = frst_cnt;
          check_output("frst_stb", wshb_stb, 0);
          check_output("frst_cyc", wshb_cyc, 0);
          check_output("frst_adr", wshb_adr, BASE_ADR);
        end
        case (rd_mode)
          1:       pix_rd = !pix_empty && ($urandom_range(3, 0) != 0);
          2:       pix_rd = 1'($urandom_range(1, 0));
          default: pix_rd = 1'b0;
        endcase
      end
    end
  end

  task automatic apply_stimulus(input int cycles, input int wmax, input int rmode, input int frst_every);
    max_wait = wmax;
    rd_mode  = rmode;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge clk);
      if (frst_every > 0 && (i % frst_every) == 0) frst_req_cnt++;
    end
  endtask

  initial begin : main
    bit seen;
    repeat (3) @(negedge clk);
    check_output("rst_stb", wshb_stb, 0);
    check_output("rst_cyc", wshb_cyc, 0);
    check_output("rst_adr", wshb_adr, BASE_ADR);
    check_output("rst_cti", 32'(wshb_cti), 0);
    check_output("rst_empty", pix_empty, 1);
    check_output("rst_underflow", underflow, 0);
    check_output("const_we", wshb_we, 0);
    check_output("const_sel", 32'(wshb_sel), 3);
    check_output("const_bte", 32'(wshb_bte), 0);
    check_output("const_dat_ms", wshb_dat_ms, 0);

    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_output("first_stb_not_yet", wshb_stb, 0);
    @(negedge clk);
    check_output("first_stb", wshb_stb, 1);

    // Fill with no consumer: requests must stop at the almost-full threshold.
    apply_stimulus(600, 0, 0, 0);
    @(negedge clk);
    check_output("throttle_level", exp_q.size(), ALMOST_FULL);
    check_output("throttle_stb", wshb_stb, 0);

    // Streaming with random wait states, wrapping the 8-pixel frame many times.
    apply_stimulus(400, 3, 1, 0);

    // Fixed five-cycle wait states.
    fixed_wait = 1'b1;
    apply_stimulus(100, 0, 1, 0);
    fixed_wait = 1'b0;

    // frame_rst in the same cycle as an ack: the word must be dropped.
    frst_ack_arm++;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      seen = (frst_ack_done == frst_ack_arm);
    end
    check_output("frst_with_ack_seen", seen, 1);

    // Reads regardless of emptiness, with periodic frame restarts clearing underflow.
    apply_stimulus(300, 2, 2, 97);
    apply_stimulus(300, 1, 1, 61);

    // Asynchronous reset in the middle of a request.
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      seen = wshb_stb;
    end
    check_output("stb_before_async_rst", seen, 1);
    #2 rst = 1'b0;
    #1;
    check_output("async_rst_stb", wshb_stb, 0);
    check_output("async_rst_cyc", wshb_cyc, 0);
    check_output("async_rst_empty", pix_empty, 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    apply_stimulus(200, 2, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
